memread_mac_pipe: RTL and testbench

- Parametrised pipelined multiply / multiply-accumulate unit for the memRead datapath.
- Generalises the fixed 14x16 unsigned 4-stage multiplier:
  - configurable operand and result widths, pipeline depth and per-operand signedness;
  - valid/first/last sideband tracking;
  - runtime-selectable accumulate mode for address/offset and dot-product computation.
- Global clock-enable stall, matching the existing HLS multiplier interface.

---
 rtl/memread_mac_pipe.sv | 148 ++++++++++++++
 tb/tb_memread_mac_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memread_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit for the memRead datapath.
// Stage 1 registers operands and sideband. Stage 2 forms the full-precision
// product. Stages 3..NUM_STAGE-1 are plain delay registers that a DSP can
// absorb. Stage NUM_STAGE is the output/accumulator register.
module memread_mac_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 4,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 16,
  parameter int dout_WIDTH  = 30,
  parameter bit din0_SIGNED = 1'b0,
  parameter bit din1_SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_mode,
  input  logic                  din_first,
  input  logic                  din_last,
  output logic                  dout_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_last
);

  localparam int PW         = din0_WIDTH + din1_WIDTH;
  localparam int LS         = NUM_STAGE - 1;  // last stage before the output register
  localparam bit OUT_SIGNED = din0_SIGNED || din1_SIGNED;

  // Sideband bit positions inside each stage's sideband word.
  localparam int SB_V = 3;
  localparam int SB_M = 2;
  localparam int SB_F = 1;
  localparam int SB_L = 0;

  // Reject parameter sets the datapath cannot represent.
  generate
    if (NUM_STAGE < 3 || NUM_STAGE > 8 || dout_WIDTH < PW || ID < 0) begin : g_param_check
      $error("memread_mac_pipe: illegal parameterisation");
    end
  endgenerate

  logic [din0_WIDTH-1:0] a_q;
  logic [din1_WIDTH-1:0] b_q;
  logic [3:0]            sb_q   [1:LS];
  logic [PW-1:0]         prod_q [2:LS];

  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod_d;
  logic [dout_WIDTH-1:0] prod_ext;

  logic [dout_WIDTH-1:0] acc_q, acc_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;

  // Stage 1 input capture plus the sideband shift chain through stage NUM_STAGE-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 1; i <= LS; i++) begin
        sb_q[i] <= '0;
      end
    end else if (ce) begin
      a_q     <= din0;
      b_q     <= din1;
      sb_q[1] <= {din_valid, acc_mode, din_first, din_last};
      for (int i = 2; i <= LS; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Extend both operands to the product width so one unsigned multiply gives
  // the correct two's-complement result modulo 2^PW for any signedness mix.
  always_comb begin
    a_ext  = din0_SIGNED ? {{din1_WIDTH{a_q[din0_WIDTH-1]}}, a_q} : {{din1_WIDTH{1'b0}}, a_q};
    b_ext  = din1_SIGNED ? {{din0_WIDTH{b_q[din1_WIDTH-1]}}, b_q} : {{din0_WIDTH{1'b0}}, b_q};
    prod_d = a_ext * b_ext;
  end

  // Stage 2 product register followed by retimable delay stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 2; i <= LS; i++) begin
        prod_q[i] <= '0;
      end
    end else if (ce) begin
      prod_q[2] <= prod_d;
      for (int i = 3; i <= LS; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  // Widen the product to the accumulator width; sign-extend when any operand is signed.
  generate
    if (dout_WIDTH > PW) begin : g_ext
      assign prod_ext = {{(dout_WIDTH - PW){OUT_SIGNED & prod_q[LS][PW-1]}}, prod_q[LS]};
    end else begin : g_noext
      assign prod_ext = prod_q[LS];
    end
  endgenerate

  // Output stage: plain product, new sum, or running sum; holds on invalid beats.
  always_comb begin
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = sb_q[LS][SB_V];
    dout_last_d  = sb_q[LS][SB_V] & sb_q[LS][SB_L];
    if (sb_q[LS][SB_V]) begin
      if (sb_q[LS][SB_M]) begin
        if (sb_q[LS][SB_F]) begin
          acc_d = prod_ext;
        end else begin
          acc_d = acc_q + prod_ext;
        end
        dout_d = acc_d;
      end else begin
        dout_d = prod_ext;
      end
    end
  end

  // Output and accumulator registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else if (ce) begin
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_memread_mac_pipe.sv
// Directed bench for memread_mac_pipe: a default unsigned 14x16->30 instance
// and a signed 8x8->20 instance share clock, reset and ce. Expected beats are
// queued when driven and popped by per-instance monitors on the falling edge.
module tb_memread_mac_pipe;

  localparam int N = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic        u_valid, u_mode, u_first, u_last;
  logic [13:0] u_din0;
  logic [15:0] u_din1;
  logic        u_dout_valid, u_dout_last;
  logic [29:0] u_dout;

  logic        s_valid, s_mode, s_first, s_last;
  logic [7:0]  s_din0, s_din1;
  logic        s_dout_valid, s_dout_last;
  logic [19:0] s_dout;

  exp_t q_u[$];
  exp_t q_s[$];

  int n_assert = 0;
  int n_fail   = 0;
  int ce_cnt   = 0;
  logic ce_e  = 1'b0;
  logic rst_e = 1'b0;

  logic [29:0] u_prev_dout;
  logic        u_prev_valid;
  logic [19:0] s_prev_dout;
  logic        s_prev_valid;

  always #5 clk = ~clk;

  memread_mac_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(u_valid),
    .din0(u_din0), .din1(u_din1), .acc_mode(u_mode),
    .din_first(u_first), .din_last(u_last),
    .dout_valid(u_dout_valid), .dout(u_dout), .dout_last(u_dout_last)
  );

  memread_mac_pipe #(
    .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(20),
    .din0_SIGNED(1'b1), .din1_SIGNED(1'b1)
  ) s_dut (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(s_valid),
    .din0(s_din0), .din1(s_din1), .acc_mode(s_mode),
    .din_first(s_first), .din_last(s_last),
    .dout_valid(s_dout_valid), .dout(s_dout), .dout_last(s_dout_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_u(input logic [13:0] a, input logic [15:0] b, input logic m,
                       input logic f, input logic l, input logic [29:0] d);
    exp_t e;
    u_valid = 1'b1; u_din0 = a; u_din1 = b; u_mode = m; u_first = f; u_last = l;
    e.data = {2'b00, d}; e.last = l; e.cyc = ce_cnt + N;
    q_u.push_back(e);
  endtask

  task automatic set_s(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic f, input logic l, input logic [19:0] d);
    exp_t e;
    s_valid = 1'b1; s_din0 = a; s_din1 = b; s_mode = m; s_first = f; s_last = l;
    e.data = {12'h000, d}; e.last = l; e.cyc = ce_cnt + N;
    q_s.push_back(e);
  endtask

  task automatic idle_u();
    u_valid = 1'b0; u_first = 1'b0; u_last = 1'b0;
  endtask

  task automatic idle_s();
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  // Record what each rising edge did so the monitors know whether outputs may move.
  always @(posedge clk) begin
    ce_e  <= ce;
    rst_e <= reset;
    if (reset && ce) ce_cnt <= ce_cnt + 1;
  end

  // Monitor for the unsigned instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_e && ce_e) begin
      if (u_dout_valid) begin
        if (q_u.size() == 0) begin
          check("u_extra_beat", {31'b0, u_dout_valid}, 32'd0);
        end else begin
          e = q_u.pop_front();
          $display("u beat: dout=%0d last=%0b cyc=%0d", u_dout, u_dout_last, ce_cnt);
          check("u_data", {2'b00, u_dout}, e.data);
          check("u_last", {31'b0, u_dout_last}, {31'b0, e.last});
          check("u_latency", ce_cnt, e.cyc);
        end
      end else begin
        check("u_last_idle", {31'b0, u_dout_last}, 32'd0);
      end
    end else if (rst_e && !ce_e) begin
      check("u_hold_dout", {2'b00, u_dout}, {2'b00, u_prev_dout});
      check("u_hold_valid", {31'b0, u_dout_valid}, {31'b0, u_prev_valid});
    end
    u_prev_dout  = u_dout;
    u_prev_valid = u_dout_valid;
  end

  // Monitor for the signed instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_e && ce_e) begin
      if (s_dout_valid) begin
        if (q_s.size() == 0) begin
          check("s_extra_beat", {31'b0, s_dout_valid}, 32'd0);
        end else begin
          e = q_s.pop_front();
          $display("s beat: dout=0x%05h last=%0b cyc=%0d", s_dout, s_dout_last, ce_cnt);
          check("s_data", {12'h000, s_dout}, e.data);
          check("s_last", {31'b0, s_dout_last}, {31'b0, e.last});
          check("s_latency", ce_cnt, e.cyc);
        end
      end else begin
        check("s_last_idle", {31'b0, s_dout_last}, 32'd0);
      end
    end else if (rst_e && !ce_e) begin
      check("s_hold_dout", {12'h000, s_dout}, {12'h000, s_prev_dout});
      check("s_hold_valid", {31'b0, s_dout_valid}, {31'b0, s_prev_valid});
    end
    s_prev_dout  = s_dout;
    s_prev_valid = s_dout_valid;
  end

  initial begin
    reset = 1'b0; ce = 1'b1;
    u_valid = 1'b0; u_din0 = '0; u_din1 = '0; u_mode = 1'b0; u_first = 1'b0; u_last = 1'b0;
    s_valid = 1'b0; s_din0 = '0; s_din1 = '0; s_mode = 1'b0; s_first = 1'b0; s_last = 1'b0;
    repeat (2) tick();
    check("rst_u_valid", {31'b0, u_dout_valid}, 32'd0);
    check("rst_u_dout", {2'b00, u_dout}, 32'd0);
    check("rst_u_last", {31'b0, u_dout_last}, 32'd0);
    check("rst_s_valid", {31'b0, s_dout_valid}, 32'd0);
    check("rst_s_dout", {12'h000, s_dout}, 32'd0);
    check("rst_s_last", {31'b0, s_dout_last}, 32'd0);
    reset = 1'b1;

    // Plain multiply: (2^14-1)*(2^16-1) = 1073659905; signed -3*7 and -128*-128.
    set_u(14'd16383, 16'd65535, 1'b0, 1'b0, 1'b1, 30'd1073659905);
    set_s(8'hFD, 8'h07, 1'b0, 1'b0, 1'b0, 20'hFFFEB);
    tick();
    set_u(14'd3, 16'd4, 1'b0, 1'b1, 1'b0, 30'd12);
    set_s(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 20'h04000);
    tick();
    idle_u(); idle_s();
    repeat (6) tick();

    // Accumulate groups, back-to-back, then mode switches per beat.
    set_u(14'd2, 16'd3, 1'b1, 1'b1, 1'b0, 30'd6);
    set_s(8'hFD, 8'h07, 1'b1, 1'b1, 1'b0, 20'hFFFEB);
    tick();
    set_u(14'd4, 16'd5, 1'b1, 1'b0, 1'b0, 30'd26);
    set_s(8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 20'hFFFEF);
    tick();
    set_u(14'd6, 16'd7, 1'b1, 1'b0, 1'b1, 30'd68);
    set_s(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b1, 20'hFFF70);
    tick();
    set_u(14'd1, 16'd1, 1'b1, 1'b1, 1'b1, 30'd1);
    idle_s();
    tick();
    set_u(14'd5, 16'd5, 1'b0, 1'b0, 1'b0, 30'd25);
    tick();
    set_u(14'd1, 16'd2, 1'b1, 1'b0, 1'b1, 30'd3);
    tick();
    idle_u();
    repeat (6) tick();

    // Wrap-around: 2*1073659905 mod 2^30 = 1073577986.
    set_u(14'd16383, 16'd65535, 1'b1, 1'b1, 1'b0, 30'd1073659905);
    tick();
    set_u(14'd16383, 16'd65535, 1'b1, 1'b0, 1'b1, 30'd1073577986);
    tick();
    idle_u();
    repeat (6) tick();

    // Stall: three beats in flight, ce low for 5 cycles with junk on the inputs.
    set_u(14'd10, 16'd10, 1'b0, 1'b0, 1'b0, 30'd100);
    tick();
    set_u(14'd11, 16'd11, 1'b0, 1'b0, 1'b0, 30'd121);
    tick();
    set_u(14'd12, 16'd12, 1'b0, 1'b0, 1'b1, 30'd144);
    tick();
    ce = 1'b0;
    u_valid = 1'b1; u_din0 = 14'd999; u_din1 = 16'd999; u_mode = 1'b0; u_last = 1'b1;
    s_valid = 1'b1; s_din0 = 8'h11; s_din1 = 8'h22; s_mode = 1'b0; s_last = 1'b1;
    repeat (5) tick();
    ce = 1'b1;
    idle_u(); idle_s();
    repeat (8) tick();

    // Reset with three accumulate beats in flight; nothing stale may emerge.
    u_valid = 1'b1; u_mode = 1'b1; u_first = 1'b1; u_last = 1'b0; u_din0 = 14'd3; u_din1 = 16'd3;
    s_valid = 1'b1; s_mode = 1'b1; s_first = 1'b1; s_last = 1'b0; s_din0 = 8'h05; s_din1 = 8'h05;
    tick();
    u_first = 1'b0; u_din0 = 14'd1; u_din1 = 16'd1;
    s_first = 1'b0;
    tick();
    u_last = 1'b1; u_din0 = 14'd2; u_din1 = 16'd2;
    s_last = 1'b1;
    tick();
    reset = 1'b0;
    idle_u(); idle_s();
    tick();
    check("mid_rst_u_valid", {31'b0, u_dout_valid}, 32'd0);
    check("mid_rst_u_dout", {2'b00, u_dout}, 32'd0);
    check("mid_rst_u_last", {31'b0, u_dout_last}, 32'd0);
    check("mid_rst_s_valid", {31'b0, s_dout_valid}, 32'd0);
    check("mid_rst_s_dout", {12'h000, s_dout}, 32'd0);
    reset = 1'b1;

    // A sum continued without a first beat must start from a cleared accumulator.
    set_u(14'd2, 16'd5, 1'b1, 1'b0, 1'b0, 30'd10);
    set_s(8'hFE, 8'h03, 1'b1, 1'b0, 1'b1, 20'hFFFFA);
    tick();
    set_u(14'd1, 16'd3, 1'b1, 1'b0, 1'b1, 30'd13);
    idle_s();
    tick();
    idle_u();
    repeat (8) tick();

    check("u_queue_drained", q_u.size(), 32'd0);
    check("s_queue_drained", q_s.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
